// File: rtl/dma_ch_pkg.sv
// Shared constants and state type for the DMA channel command sequencer.
package dma_ch_pkg;

  localparam int CMD_ENABLE  = 0;
  localparam int CMD_CLEAR   = 1;
  localparam int CMD_DISABLE = 2;
  localparam int CMD_STOP    = 3;
  localparam int CMD_PAUSE   = 4;
  localparam int CMD_RESUME  = 5;

  localparam int INTR_DONE     = 0;
  localparam int INTR_ERR      = 1;
  localparam int INTR_DISABLED = 2;
  localparam int INTR_STOPPED  = 3;

  localparam int STAT_DONE     = 16;
  localparam int STAT_ERR      = 17;
  localparam int STAT_DISABLED = 18;
  localparam int STAT_STOPPED  = 19;
  localparam int STAT_PAUSED   = 20;
  localparam int STAT_WDOG     = 24;

  typedef enum logic [2:0] {
    IDLE, START, ACTIVE, PAUSED, LINK, DRAIN_S, DRAIN_D, ERRDRAIN
  } ch_state_e;

endpackage

// File: rtl/dma_ch_ctrl_fsm_status.sv
// CH_STATUS register: event set, W1C and CLEAR handling, interrupt reduction.
// An event set wins over a clear arriving in the same cycle.
module dma_ch_status_irq
  import dma_ch_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             w1c_en,
  input  logic [3:0]       w1c_mask,
  input  logic [3:0]       intren,
  input  logic             clr_all,
  input  logic             clr_stat,
  input  logic [3:0]       set_evt,
  input  logic             set_wdog,
  input  logic             paused,
  output logic [WIDTH-1:0] status,
  output logic             irq
);

  logic [3:0] intr_q;
  logic [3:0] stat_q;
  logic       wdog_q;
  logic [3:0] intr_clr;

  assign intr_clr = (w1c_en ? w1c_mask : 4'h0) | {4{clr_all}};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      intr_q <= 4'h0;
      stat_q <= 4'h0;
      wdog_q <= 1'b0;
    end else begin
      intr_q <= (intr_q & ~intr_clr) | set_evt;
      stat_q <= (stat_q & ~{4{clr_all | clr_stat}}) | set_evt;
      wdog_q <= (wdog_q & ~(clr_all | clr_stat)) | set_wdog;
    end
  end

  always_comb begin
    status                       = '0;
    status[INTR_STOPPED:INTR_DONE] = intr_q;
    status[STAT_STOPPED:STAT_DONE] = stat_q;
    status[STAT_PAUSED]          = paused;
    status[STAT_WDOG]            = wdog_q;
  end

  assign irq = |(intr_q & intren);

endmodule

// File: rtl/dma_ch_ctrl_fsm.sv
// DMA channel command sequencer: CH_CMD decode, datapath handshakes, descriptor linking.
// Optional beat watchdog enabled by defining DMA_CH_WATCHDOG_EN.
//
// state    | meaning
// IDLE     | channel off, waiting for ENABLE
// START    | one-cycle start pulse to the datapath
// ACTIVE   | transfer running
// PAUSED   | datapath paused, waiting for RESUME
// LINK     | fetching the next linked descriptor
// DRAIN_S  | STOP: abort held until datapath idle
// DRAIN_D  | DISABLE: halt held until datapath idle
// ERRDRAIN | error: abort held until datapath idle
module dma_ch_ctrl_fsm
  import dma_ch_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             cmd_wr_en,
  input  logic             stat_wr_en,
  input  logic [WIDTH-1:0] cfg_data_in,
  input  logic [WIDTH-1:0] cfg_intren,
  input  logic [WIDTH-1:0] cfg_linkaddr,
  output logic             xfer_start,
  output logic             xfer_abort,
  output logic             xfer_halt,
  output logic             xfer_pause,
  input  logic             xfer_done,
  input  logic             xfer_err,
  input  logic             xfer_idle,
  input  logic             xfer_beat,
  output logic             lnk_req,
  input  logic             lnk_ack,
  input  logic             lnk_err,
  output logic [WIDTH-1:0] ch_cmd_out,
  output logic [WIDTH-1:0] ch_status_out,
  output logic             ch_busy,
  output logic             ch_irq
);

  ch_state_e  state_q, state_d;
  logic       stop_pend_q, stop_pend_d;
  logic [3:0] set_evt;
  logic       set_wdog, clr_all, clr_stat, wdog_to;
  logic       cmd_en, cmd_clr, cmd_dis, cmd_stop, cmd_pause, cmd_res;
  logic       unused_cfg;

  assign cmd_en    = cmd_wr_en & cfg_data_in[CMD_ENABLE];
  assign cmd_clr   = cmd_wr_en & cfg_data_in[CMD_CLEAR];
  assign cmd_dis   = cmd_wr_en & cfg_data_in[CMD_DISABLE];
  assign cmd_stop  = cmd_wr_en & cfg_data_in[CMD_STOP];
  assign cmd_pause = cmd_wr_en & cfg_data_in[CMD_PAUSE];
  assign cmd_res   = cmd_wr_en & cfg_data_in[CMD_RESUME];

  assign unused_cfg = ^{cfg_data_in[WIDTH-1:6], cfg_intren[WIDTH-1:4], cfg_linkaddr[WIDTH-1:1]};

`ifdef DMA_CH_WATCHDOG_EN
  // Down-counter of beatless ACTIVE cycles; held while paused.
  localparam int CW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [CW-1:0] WDOG_LOAD = CW'(WDOG_CYCLES - 1);
  logic [CW-1:0] wdog_cnt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wdog_cnt_q <= WDOG_LOAD;
    end else if (state_q == ACTIVE) begin
      if (xfer_beat || wdog_cnt_q == '0) wdog_cnt_q <= WDOG_LOAD;
      else                               wdog_cnt_q <= wdog_cnt_q - 1'b1;
    end else if (state_q != PAUSED) begin
      wdog_cnt_q <= WDOG_LOAD;
    end
  end

  assign wdog_to = (state_q == ACTIVE) && !xfer_beat && (wdog_cnt_q == '0);
`else
  localparam int unused_wdog_cycles = WDOG_CYCLES;
  logic unused_beat;
  assign unused_beat = xfer_beat;
  assign wdog_to     = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    stop_pend_d = stop_pend_q;
    set_evt     = 4'h0;
    set_wdog    = 1'b0;
    clr_all     = 1'b0;
    clr_stat    = 1'b0;
    case (state_q)
      IDLE: begin
        stop_pend_d = 1'b0;
        clr_all     = cmd_clr;
        if (cmd_en) begin
          clr_stat = 1'b1;
          state_d  = START;
        end
      end
      START: state_d = ACTIVE;
      ACTIVE: begin
        // Priority: error/watchdog > STOP > DISABLE > done > PAUSE
        if (xfer_err || wdog_to) begin
          state_d  = ERRDRAIN;
          set_wdog = wdog_to;
        end else if (cmd_stop) begin
          state_d = DRAIN_S;
        end else if (cmd_dis) begin
          state_d = DRAIN_D;
        end else if (xfer_done) begin
          if (cfg_linkaddr[0]) begin
            state_d = LINK;
          end else begin
            state_d            = IDLE;
            set_evt[INTR_DONE] = 1'b1;
          end
        end else if (cmd_pause) begin
          state_d = PAUSED;
        end
      end
      PAUSED: begin
        if (cmd_stop)      state_d = DRAIN_S;
        else if (cmd_dis)  state_d = DRAIN_D;
        else if (cmd_res)  state_d = ACTIVE;
      end
      LINK: begin
        if (lnk_ack) begin
          stop_pend_d = 1'b0;
          if (lnk_err) begin
            state_d           = IDLE;
            set_evt[INTR_ERR] = 1'b1;
          end else if (stop_pend_q || cmd_stop) begin
            state_d               = IDLE;
            set_evt[INTR_STOPPED] = 1'b1;
          end else begin
            state_d = START;
          end
        end else if (cmd_stop) begin
          stop_pend_d = 1'b1;
        end
      end
      DRAIN_S: if (xfer_idle) begin
        state_d               = IDLE;
        set_evt[INTR_STOPPED] = 1'b1;
      end
      DRAIN_D: if (xfer_idle) begin
        state_d                = IDLE;
        set_evt[INTR_DISABLED] = 1'b1;
      end
      ERRDRAIN: if (xfer_idle) begin
        state_d           = IDLE;
        set_evt[INTR_ERR] = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign xfer_start = (state_q == START);
  assign xfer_abort = (state_q == DRAIN_S) || (state_q == ERRDRAIN);
  assign xfer_halt  = (state_q == DRAIN_D);
  assign xfer_pause = (state_q == PAUSED);
  assign lnk_req    = (state_q == LINK);
  assign ch_busy    = (state_q != IDLE);
  assign ch_cmd_out = {{(WIDTH-1){1'b0}}, ch_busy};

  dma_ch_status_irq #(.WIDTH(WIDTH)) u_status (
    .clk      (clk),
    .resetn   (resetn),
    .w1c_en   (stat_wr_en),
    .w1c_mask (cfg_data_in[3:0]),
    .intren   (cfg_intren[3:0]),
    .clr_all  (clr_all),
    .clr_stat (clr_stat),
    .set_evt  (set_evt),
    .set_wdog (set_wdog),
    .paused   (state_q == PAUSED),
    .status   (ch_status_out),
    .irq      (ch_irq)
  );

endmodule

// File: tb/tb_dma_ch_ctrl_fsm.sv
// Bench for dma_ch_ctrl_fsm: directed scenarios plus random traffic against a behavioural model.
// Define DMA_CH_WATCHDOG_EN to also exercise the watchdog (limit 16 cycles).
module tb_dma_ch_ctrl_fsm;

`ifdef DMA_CH_WATCHDOG_EN
  localparam int WD = 16;
  localparam bit WD_EN = 1'b1;
`else
  localparam int WD = 1024;
  localparam bit WD_EN = 1'b0;
`endif

  localparam int M_IDLE = 0, M_START = 1, M_RUN = 2, M_PAUSE = 3, M_LINK = 4,
                 M_STOPPING = 5, M_DISABLING = 6, M_ERRING = 7;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cmd_wr_en = 1'b0, stat_wr_en = 1'b0;
  logic [31:0] cfg_data_in = '0, cfg_intren = '0, cfg_linkaddr = '0;
  logic        xfer_start, xfer_abort, xfer_halt, xfer_pause, lnk_req, ch_busy, ch_irq;
  logic        xfer_done = 1'b0, xfer_err = 1'b0, xfer_idle = 1'b1, xfer_beat = 1'b0;
  logic        lnk_ack = 1'b0, lnk_err = 1'b0;
  logic [31:0] ch_cmd_out, ch_status_out;

  dma_ch_ctrl_fsm #(.WIDTH(32), .WDOG_CYCLES(WD)) dut (
    .clk(clk), .resetn(resetn), .cmd_wr_en(cmd_wr_en), .stat_wr_en(stat_wr_en),
    .cfg_data_in(cfg_data_in), .cfg_intren(cfg_intren), .cfg_linkaddr(cfg_linkaddr),
    .xfer_start(xfer_start), .xfer_abort(xfer_abort), .xfer_halt(xfer_halt),
    .xfer_pause(xfer_pause), .xfer_done(xfer_done), .xfer_err(xfer_err),
    .xfer_idle(xfer_idle), .xfer_beat(xfer_beat), .lnk_req(lnk_req), .lnk_ack(lnk_ack),
    .lnk_err(lnk_err), .ch_cmd_out(ch_cmd_out), .ch_status_out(ch_status_out),
    .ch_busy(ch_busy), .ch_irq(ch_irq)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int m_mode = M_IDLE;
  logic [31:0] m_stat = '0;
  bit m_pend = 1'b0;
  int m_wd = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic void m_reset();
    m_mode = M_IDLE; m_stat = '0; m_pend = 1'b0; m_wd = 0;
  endfunction

  function automatic void m_event(input int b);
    m_stat[b] = 1'b1;
    m_stat[b + 16] = 1'b1;
  endfunction

  // One clock of the channel rules, applied to the inputs sampled at this edge.
  function automatic void model_step();
    logic [31:0] d = cfg_data_in;
    bit en = cmd_wr_en && d[0], clr = cmd_wr_en && d[1], dis = cmd_wr_en && d[2];
    bit stp = cmd_wr_en && d[3], pau = cmd_wr_en && d[4], res = cmd_wr_en && d[5];
    bit tmo = WD_EN && m_mode == M_RUN && !xfer_beat && (m_wd + 1 >= WD);
    int nm = m_mode;
    if (stat_wr_en) m_stat[3:0] = m_stat[3:0] & ~d[3:0];
    case (m_mode)
      M_IDLE: begin
        m_pend = 1'b0;
        if (clr) begin m_stat[3:0] = '0; m_stat[19:16] = '0; m_stat[24] = 1'b0; end
        if (en)  begin m_stat[19:16] = '0; m_stat[24] = 1'b0; nm = M_START; end
      end
      M_START: nm = M_RUN;
      M_RUN: begin
        if (xfer_err || tmo) begin nm = M_ERRING; if (tmo) m_stat[24] = 1'b1; end
        else if (stp) nm = M_STOPPING;
        else if (dis) nm = M_DISABLING;
        else if (xfer_done) begin
          if (cfg_linkaddr[0]) nm = M_LINK;
          else begin nm = M_IDLE; m_event(0); end
        end else if (pau) nm = M_PAUSE;
      end
      M_PAUSE: begin
        if (stp) nm = M_STOPPING;
        else if (dis) nm = M_DISABLING;
        else if (res) nm = M_RUN;
      end
      M_LINK: begin
        if (lnk_ack) begin
          if (lnk_err) begin nm = M_IDLE; m_event(1); end
          else if (m_pend || stp) begin nm = M_IDLE; m_event(3); end
          else nm = M_START;
          m_pend = 1'b0;
        end else if (stp) m_pend = 1'b1;
      end
      M_STOPPING:  if (xfer_idle) begin nm = M_IDLE; m_event(3); end
      M_DISABLING: if (xfer_idle) begin nm = M_IDLE; m_event(2); end
      M_ERRING:    if (xfer_idle) begin nm = M_IDLE; m_event(1); end
      default: nm = M_IDLE;
    endcase
    if (m_mode == M_RUN)        m_wd = xfer_beat ? 0 : m_wd + 1;
    else if (m_mode != M_PAUSE) m_wd = 0;
    m_mode = nm;
  endfunction

  task automatic check_all();
    logic [31:0] exp_stat = m_stat | ((m_mode == M_PAUSE) ? 32'h0010_0000 : 32'h0);
    chk("xfer_start", 32'(xfer_start), 32'(m_mode == M_START));
    chk("xfer_abort", 32'(xfer_abort), 32'(m_mode == M_STOPPING || m_mode == M_ERRING));
    chk("xfer_halt", 32'(xfer_halt), 32'(m_mode == M_DISABLING));
    chk("xfer_pause", 32'(xfer_pause), 32'(m_mode == M_PAUSE));
    chk("lnk_req", 32'(lnk_req), 32'(m_mode == M_LINK));
    chk("ch_busy", 32'(ch_busy), 32'(m_mode != M_IDLE));
    chk("ch_cmd_out", ch_cmd_out, 32'(m_mode != M_IDLE));
    chk("ch_status", ch_status_out, exp_stat);
    chk("ch_irq", 32'(ch_irq), 32'(|(m_stat[3:0] & cfg_intren[3:0])));
  endtask

  task automatic tick();
    @(posedge clk);
    if (resetn) model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic do_cmd(input logic [31:0] d);
    cmd_wr_en = 1'b1; cfg_data_in = d;
    tick();
    cmd_wr_en = 1'b0; cfg_data_in = '0;
  endtask

  task automatic enable_run();
    do_cmd(32'h2);
    xfer_idle = 1'b0;
    do_cmd(32'h1);
    tick();
  endtask

  initial begin
    @(negedge clk);
    check_all();
    chk("rst_status", ch_status_out, 32'h0);
    chk("rst_busy", 32'(ch_busy), 32'h0);
    resetn = 1'b1;

    // Single descriptor, no link.
    cfg_intren = 32'h1; cfg_linkaddr = 32'h0; xfer_idle = 1'b0;
    cmd_wr_en = 1'b1; cfg_data_in = 32'h1;
    tick();
    chk("t1_start", 32'(xfer_start), 32'h1);
    cmd_wr_en = 1'b0; cfg_data_in = '0;
    tick();
    repeat (8) tick();
    xfer_done = 1'b1;
    tick();
    xfer_done = 1'b0; xfer_idle = 1'b1;
    chk("t1_status", ch_status_out, 32'h0001_0001);
    chk("t1_busy", 32'(ch_busy), 32'h0);
    chk("t1_irq", 32'(ch_irq), 32'h1);

    // Linked descriptor then plain completion.
    cfg_linkaddr = 32'h1;
    enable_run();
    xfer_done = 1'b1;
    tick();
    chk("t2_lnk_req", 32'(lnk_req), 32'h1);
    xfer_done = 1'b0; xfer_idle = 1'b1;
    tick();
    lnk_ack = 1'b1;
    tick();
    chk("t2_restart", 32'(xfer_start), 32'h1);
    lnk_ack = 1'b0; cfg_linkaddr = 32'h0; xfer_idle = 1'b0;
    tick();
    xfer_done = 1'b1;
    tick();
    xfer_done = 1'b0; xfer_idle = 1'b1;
    chk("t2_status", ch_status_out, 32'h0001_0001);

    // STOP with delayed datapath idle.
    enable_run();
    do_cmd(32'h8);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3_abort", 32'(xfer_abort), 32'h1);
    end
    xfer_idle = 1'b1;
    tick();
    chk("t3_status", ch_status_out, 32'h0008_0008);

    // DISABLE and PAUSE together: DISABLE wins.
    enable_run();
    do_cmd(32'h14);
    chk("t4_halt", 32'(xfer_halt), 32'h1);
    chk("t4_nopause", 32'(ch_status_out[20]), 32'h0);
    repeat (3) tick();
    xfer_idle = 1'b1;
    tick();
    chk("t4_status", ch_status_out, 32'h0004_0004);

    // PAUSE/RESUME, then error coinciding with STOP.
    cfg_intren = 32'hF;
    enable_run();
    do_cmd(32'h10);
    chk("t5_pause", 32'(xfer_pause), 32'h1);
    chk("t5_stat_paused", 32'(ch_status_out[20]), 32'h1);
    tick();
    do_cmd(32'h20);
    chk("t5_resumed", 32'(xfer_pause), 32'h0);
    xfer_err = 1'b1;
    do_cmd(32'h8);
    xfer_err = 1'b0;
    tick();
    xfer_idle = 1'b1;
    tick();
    chk("t5_status", ch_status_out, 32'h0002_0002);

`ifdef DMA_CH_WATCHDOG_EN
    cfg_intren = 32'h2; xfer_beat = 1'b0;
    enable_run();
    repeat (WD - 1) tick();
    chk("wd_not_yet", 32'(xfer_abort), 32'h0);
    tick();
    chk("wd_abort", 32'(xfer_abort), 32'h1);
    xfer_idle = 1'b1;
    tick();
    chk("wd_status", ch_status_out, 32'h0102_0002);
    stat_wr_en = 1'b1; cfg_data_in = 32'h2;
    tick();
    stat_wr_en = 1'b0; cfg_data_in = '0;
    chk("wd_irq_clr", 32'(ch_irq), 32'h0);
`else
    xfer_beat = 1'b0;
    enable_run();
    repeat (40) tick();
    chk("nowd_busy", 32'(ch_busy), 32'h1);
    chk("nowd_bit24", 32'(ch_status_out[24]), 32'h0);
    do_cmd(32'h8);
    xfer_idle = 1'b1;
    tick();
`endif

    // Random traffic checked against the model every cycle.
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) begin
        resetn = 1'b0;
        m_reset();
        #1 check_all();
        tick();
        resetn = 1'b1;
      end
      cmd_wr_en  = ($urandom % 6) == 0;
      stat_wr_en = !cmd_wr_en && (($urandom % 10) == 0);
      cfg_data_in = $urandom;
      if (cmd_wr_en) begin
        case ($urandom % 8)
          0, 1, 2, 3, 4, 5: cfg_data_in = 32'h1 << ($urandom % 6);
          default:          cfg_data_in = (($urandom % 15) + 1) << 2;
        endcase
        if (m_mode == M_IDLE && ($urandom % 3) == 0) cfg_data_in = 32'h1;
      end
      cfg_intren   = $urandom;
      cfg_linkaddr = $urandom % 2;
      xfer_beat    = $urandom % 2;
      xfer_done    = (m_mode == M_RUN) && (($urandom % 8) == 0);
      xfer_err     = (m_mode == M_RUN) && (($urandom % 40) == 0);
      lnk_ack      = (m_mode == M_LINK) && (($urandom % 3) == 0);
      lnk_err      = ($urandom % 4) == 0;
      if (m_mode == M_STOPPING || m_mode == M_DISABLING || m_mode == M_ERRING)
        xfer_idle = ($urandom % 4) == 0;
      else
        xfer_idle = !(m_mode == M_START || m_mode == M_RUN || m_mode == M_PAUSE);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
